lfsr_roller: RTL and testbench



---
 rtl/lfsr_roller_pkg.sv | 14 +
 rtl/galois_lfsr.sv | 34 +++
 rtl/lfsr_roller.sv | 143 ++++++++++++++
 tb/tb_lfsr_roller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_roller_pkg.sv
// Shared types and sizing helpers for the dice roller.
// The timer width covers the longest interval of a roll without overflow.
package lfsr_roller_pkg;

    typedef enum logic {
        S_IDLE,
        S_ROLL
    } state_t;

    function automatic int tmr_width(input int base_iv, input int n_steps, input int step_inc);
        return $clog2(base_iv + (n_steps - 1) * step_inc + 1);
    endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Galois LFSR with seed load and single-step advance; a zero seed becomes 1.
// One-cycle update; load beats advance, no backpressure.
module galois_lfsr
    import lfsr_roller_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_adv,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] next_w;

    assign next_w  = {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? TAPS : '0);
    assign o_state = state_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= LFSR_W'(1);
        end else if (i_load) begin
            // All-zeros is the lock-up state of an XOR LFSR
            state_q <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
        end else if (i_adv) begin
            state_q <= next_w;
        end
    end

endmodule

// File: rtl/lfsr_roller.sv
// Decelerating dice roller: N_STEPS LFSR updates at growing intervals after each start.
// Output and pulses are registered on the update edge; start/stop are single-cycle pulses, no backpressure.
module lfsr_roller
    import lfsr_roller_pkg::*;
#(
    parameter int                LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] TAPS          = 16'hB400,
    parameter int                OUT_W         = 4,
    parameter int                N_STEPS       = 16,
    parameter int                BASE_INTERVAL = 1_000_000,
    parameter int                STEP_INC      = 500_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [OUT_W-1:0] o_random_out,
    output logic             o_step,
    output logic             o_busy,
    output logic             o_done
);

    localparam int TMR_W  = tmr_width(BASE_INTERVAL, N_STEPS, STEP_INC);
    localparam int STEP_W = $clog2(N_STEPS + 1);

    localparam logic [TMR_W-1:0]  BASE_V = TMR_W'(BASE_INTERVAL);
    localparam logic [TMR_W-1:0]  INC_V  = TMR_W'(STEP_INC);
    localparam logic [TMR_W-1:0]  ONE_T  = TMR_W'(1);
    localparam logic [STEP_W-1:0] LAST_V = STEP_W'(N_STEPS - 1);
    localparam logic [STEP_W-1:0] ONE_S  = STEP_W'(1);

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] seed_cnt_q;
    logic [LFSR_W-1:0] lfsr_state;
    logic [LFSR_W-1:0] lfsr_next;
    logic [TMR_W-1:0]  tmr_q;
    logic [TMR_W-1:0]  intv_q;
    logic [TMR_W-1:0]  intv_nxt;
    logic [STEP_W-1:0] step_cnt_q;
    logic [OUT_W-1:0]  rnd_q;
    logic              step_q;
    logic              done_q;
    logic              do_load;
    logic              do_adv;
    logic              last_step;

    galois_lfsr #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (do_load),
        .i_seed  (seed_cnt_q),
        .i_adv   (do_adv),
        .o_state (lfsr_state)
    );

    // Same advance as the LFSR so the display updates on the same edge
    assign lfsr_next = {1'b0, lfsr_state[LFSR_W-1:1]} ^ (lfsr_state[0] ? TAPS : '0);
    assign intv_nxt  = intv_q + INC_V;

    generate
        if (OUT_W < LFSR_W) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^lfsr_next[LFSR_W-1:OUT_W];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        do_load   = 1'b0;
        do_adv    = 1'b0;
        last_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    do_load = 1'b1;
                    state_d = S_ROLL;
                end
            end
            S_ROLL: begin
                if (i_start) begin
                    do_load = 1'b1;
                end else if (i_stop) begin
                    state_d = S_IDLE;
                end else if (tmr_q == '0) begin
                    do_adv = 1'b1;
                    if (step_cnt_q == LAST_V) begin
                        last_step = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seed_cnt_q <= '0;
            tmr_q      <= '0;
            intv_q     <= '0;
            step_cnt_q <= '0;
            rnd_q      <= '0;
            step_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            seed_cnt_q <= seed_cnt_q + LFSR_W'(1);
            step_q     <= do_adv;
            done_q     <= last_step;
            if (do_load) begin
                step_cnt_q <= '0;
                intv_q     <= BASE_V;
                tmr_q      <= BASE_V - ONE_T;
            end else if (do_adv) begin
                rnd_q      <= lfsr_next[OUT_W-1:0];
                step_cnt_q <= step_cnt_q + ONE_S;
                // The interval past the final update is never needed and could overflow
                if (!last_step) begin
                    intv_q <= intv_nxt;
                    tmr_q  <= intv_nxt - ONE_T;
                end
            end else if (state_q == S_ROLL && tmr_q != '0) begin
                tmr_q <= tmr_q - ONE_T;
            end
        end
    end

    assign o_random_out = rnd_q;
    assign o_step       = step_q;
    assign o_busy       = (state_q == S_ROLL);
    assign o_done       = done_q;

endmodule

// File: tb/tb_lfsr_roller.sv
// Scoreboard bench for lfsr_roller: expected updates queued at each start, matched on o_step/o_done.
module tb_lfsr_roller;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       i_stop;
    logic [3:0] o_random_out;
    logic       o_step;
    logic       o_busy;
    logic       o_done;

    lfsr_roller #(
        .LFSR_W        (8),
        .TAPS          (8'hB8),
        .OUT_W         (4),
        .N_STEPS       (4),
        .BASE_INTERVAL (2),
        .STEP_INC      (1)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .o_random_out (o_random_out),
        .o_step       (o_step),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } sb_t;

    sb_t        sb_q[$];
    int         done_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [7:0] seed_m = 8'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic push_roll(input int s_cyc, input logic [7:0] seed, input int n, input bit with_done);
        logic [7:0] l;
        int         t;
        int         iv;
        l  = (seed == 8'd0) ? 8'd1 : seed;
        t  = s_cyc;
        iv = 2;
        for (int k = 0; k < n; k++) begin
            t = t + iv;
            l = lfsr_adv(l);
            sb_q.push_back('{cyc: t, val: l[3:0]});
            iv = iv + 1;
        end
        if (with_done) done_q.push_back(t);
    endtask

    // Advance one edge, track the seed counter, then score outputs 1ns later
    task automatic tick();
        sb_t e;
        int  d;
        @(posedge i_clk);
        if (i_rst) seed_m = 8'd0;
        else       seed_m = seed_m + 8'd1;
        #1;
        cyc++;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            chk("step_miss", cyc, e.cyc);
        end
        while (done_q.size() > 0 && done_q[0] < cyc) begin
            d = done_q.pop_front();
            chk("done_miss", cyc, d);
        end
        if (o_step) begin
            if (sb_q.size() == 0) begin
                chk("step_unexp", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("step_cyc", cyc, e.cyc);
                chk("step_val", o_random_out, e.val);
            end
        end
        if (o_done) begin
            if (done_q.size() == 0) begin
                chk("done_unexp", 1, 0);
            end else begin
                d = done_q.pop_front();
                chk("done_cyc", cyc, d);
            end
        end
    endtask

    task automatic reset_idle(input int n_idle);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        repeat (n_idle) tick();
    endtask

    initial begin
        int s;
        int busy_cnt;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        repeat (3) tick();
        chk("rst_out",  o_random_out, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_step", o_step, 0);
        chk("rst_done", o_done, 0);
        chk("rst_lfsr", dut.u_lfsr.o_state, 8'h01);
        chk("rst_seed", dut.seed_cnt_q, 0);

        // Start on the very first edge after reset: seed 0 is replaced by 1
        i_rst   = 1'b0;
        i_start = 1'b1;
        push_roll(cyc + 1, seed_m, 4, 1'b1);
        tick();
        i_start = 1'b0;
        chk("seed0_lfsr", dut.u_lfsr.o_state, 8'h01);
        tick();
        tick();
        chk("seed0_lfsr_b8", dut.u_lfsr.o_state, 8'hB8);
        chk("seed0_out", o_random_out, 4'h8);
        repeat (14) tick();
        chk("seed0_sb_empty", sb_q.size(), 0);
        chk("seed0_busy_end", o_busy, 0);

        // Seed 5: A, D, 6, B at +2, +5, +9, +14
        reset_idle(5);
        i_start = 1'b1;
        s = cyc + 1;
        sb_q.push_back('{cyc: s + 2,  val: 4'hA});
        sb_q.push_back('{cyc: s + 5,  val: 4'hD});
        sb_q.push_back('{cyc: s + 9,  val: 4'h6});
        sb_q.push_back('{cyc: s + 14, val: 4'hB});
        done_q.push_back(s + 14);
        tick();
        i_start = 1'b0;
        chk("start_out_hold", o_random_out, 0);
        busy_cnt = o_busy ? 1 : 0;
        repeat (19) begin
            tick();
            if (o_busy) busy_cnt++;
        end
        chk("seed5_busy_cycles", busy_cnt, 14);
        chk("seed5_sb_empty", sb_q.size(), 0);
        chk("seed5_done_empty", done_q.size(), 0);

        // Stop one cycle after the second update
        reset_idle(5);
        i_start = 1'b1;
        s = cyc + 1;
        sb_q.push_back('{cyc: s + 2, val: 4'hA});
        sb_q.push_back('{cyc: s + 5, val: 4'hD});
        tick();
        i_start = 1'b0;
        repeat (5) tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("stop_busy", o_busy, 0);
        chk("stop_out", o_random_out, 4'hD);
        repeat (15) tick();
        chk("stop_out_frozen", o_random_out, 4'hD);
        chk("stop_sb_empty", sb_q.size(), 0);

        // Restart on the edge the first timer expires
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_start = 1'b1;
        push_roll(cyc + 1, seed_m, 4, 1'b1);
        tick();
        i_start = 1'b0;
        chk("restart_nostep", o_step, 0);
        chk("restart_busy", o_busy, 1);
        repeat (16) tick();
        chk("restart_sb_empty", sb_q.size(), 0);
        chk("restart_done_empty", done_q.size(), 0);
        chk("restart_busy_end", o_busy, 0);

        // Reset after the third update
        i_start = 1'b1;
        push_roll(cyc + 1, seed_m, 3, 1'b0);
        tick();
        i_start = 1'b0;
        repeat (10) tick();
        i_rst = 1'b1;
        tick();
        chk("midrst_out",  o_random_out, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_done", o_done, 0);
        chk("midrst_lfsr", dut.u_lfsr.o_state, 8'h01);
        chk("midrst_seed", dut.seed_cnt_q, 0);
        i_rst = 1'b0;
        repeat (20) tick();
        chk("midrst_sb_empty", sb_q.size(), 0);

        // Stop alone in IDLE is ignored; start with stop starts a roll
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("idle_stop_busy", o_busy, 0);
        i_start = 1'b1;
        i_stop  = 1'b1;
        push_roll(cyc + 1, seed_m, 4, 1'b1);
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk("both_busy", o_busy, 1);
        repeat (16) tick();
        chk("both_sb_empty", sb_q.size(), 0);
        chk("both_done_empty", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
